// File: rtl/keypad_pkg.sv
// Shared keypad definitions: special key codes, row/event state encodings and
// the row/column to key-code map.
package keypad_pkg;

   localparam logic [3:0] KEY_NONE = 4'hF;
   localparam logic [3:0] KEY_STAR = 4'd10;
   localparam logic [3:0] KEY_HASH = 4'd11;

   typedef enum logic [1:0] {
      ROW_B = 2'd0,
      ROW_G = 2'd1,
      ROW_F = 2'd2,
      ROW_D = 2'd3
   } row_e;

   typedef enum logic {
      IDLE = 1'b0,
      HELD = 1'b1
   } ev_e;

   // sense is {E,A,C}; within a row column C has priority, then A, then E
   function automatic logic [3:0] row_col_to_code(input row_e row, input logic [2:0] sense);
      logic [3:0] code_c;
      logic [3:0] code_a;
      logic [3:0] code_e;
      logic [3:0] code;
      case (row)
         ROW_B:   begin code_c = 4'd1;     code_a = 4'd2;     code_e = 4'd3;     end
         ROW_G:   begin code_c = 4'd4;     code_a = 4'd5;     code_e = 4'd6;     end
         ROW_F:   begin code_c = 4'd7;     code_a = 4'd8;     code_e = 4'd9;     end
         ROW_D:   begin code_c = KEY_STAR; code_a = 4'd0;     code_e = KEY_HASH; end
         default: begin code_c = KEY_NONE; code_a = KEY_NONE; code_e = KEY_NONE; end
      endcase
      if (sense[0]) begin
         code = code_c;
      end else if (sense[1]) begin
         code = code_a;
      end else if (sense[2]) begin
         code = code_e;
      end else begin
         code = KEY_NONE;
      end
      return code;
   endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Scan-level debouncer: a candidate code must repeat on DEBOUNCE_SCANS
// consecutive scan ends before it becomes the stable code.
module keypad_debounce
   import keypad_pkg::*;
#(
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scan_end,
   input  logic [3:0] cand,
   output logic [3:0] stable,
   output logic       load
);

   localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic [3:0]    prev_q;
   logic [3:0]    prev_d;
   logic [3:0]    stable_q;
   logic [3:0]    stable_d;
   logic          load_s;

   // Repeat count saturates so a long hold never wraps back below threshold
   always_comb begin
      cnt_d    = cnt_q;
      prev_d   = prev_q;
      stable_d = stable_q;
      load_s   = 1'b0;
      if (scan_end) begin
         prev_d = cand;
         if (cand == prev_q) begin
            if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + 1'b1;
            end else begin
               cnt_d = cnt_q;
            end
         end else begin
            cnt_d = CW'(1);
         end
         if (cnt_d == CNT_MAX) begin
            load_s   = 1'b1;
            stable_d = cand;
         end else begin
            load_s   = 1'b0;
            stable_d = stable_q;
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         prev_q   <= KEY_NONE;
         stable_q <= KEY_NONE;
      end else begin
         cnt_q    <= cnt_d;
         prev_q   <= prev_d;
         stable_q <= stable_d;
      end
   end

   assign stable = stable_q;
   assign load   = load_s;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x3 keypad scanner with debounce and a valid/ack event interface.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scan_ctrl
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV       = 50000,
   parameter int DEBOUNCE_SCANS = 4,
   parameter int REPEAT_SCANS   = 200
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [2:0] SENSE,
   output logic [3:0] DRIVE,
   output logic [3:0] KEY_DATA,
   output logic       KEY_VALID,
   input  logic       KEY_ACK,
   output logic       INTR
);

   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

   row_e          row_q;
   row_e          row_d;
   logic [DW-1:0] dwell_q;
   logic [DW-1:0] dwell_d;
   logic [3:0]    acc_q;
   logic [3:0]    acc_d;
   ev_e           ev_q;
   ev_e           ev_d;
   logic [3:0]    data_q;
   logic [3:0]    data_d;
   logic          valid_q;
   logic          valid_d;
   logic          intr_q;
   logic          intr_d;

   logic          sample_s;
   logic          scan_end_s;
   logic [3:0]    row_code_s;
   logic [3:0]    cand_s;
   logic [3:0]    stable_s;
   logic          deb_load_s;
   logic [3:0]    stable_nx_s;
   logic          new_press_s;
   logic          event_s;

   assign sample_s   = (dwell_q == DWELL_LAST);
   assign scan_end_s = sample_s && (row_q == ROW_D);
   assign row_code_s = row_col_to_code(row_q, SENSE);
   // First pressed key in row order wins, so an earlier row's hit is kept
   assign cand_s     = (acc_q != KEY_NONE) ? acc_q : row_code_s;

   always_ff @(posedge CLK) begin
      if (RST) begin
         row_q   <= ROW_B;
         dwell_q <= '0;
         acc_q   <= KEY_NONE;
         ev_q    <= IDLE;
         data_q  <= KEY_NONE;
         valid_q <= 1'b0;
         intr_q  <= 1'b0;
      end else begin
         row_q   <= row_d;
         dwell_q <= dwell_d;
         acc_q   <= acc_d;
         ev_q    <= ev_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         intr_q  <= intr_d;
      end
   end

   always_comb begin
      row_d   = row_q;
      dwell_d = dwell_q + 1'b1;
      acc_d   = acc_q;
      if (sample_s) begin
         dwell_d = '0;
         acc_d   = scan_end_s ? KEY_NONE : cand_s;
         case (row_q)
            ROW_B:   row_d = ROW_G;
            ROW_G:   row_d = ROW_F;
            ROW_F:   row_d = ROW_D;
            ROW_D:   row_d = ROW_B;
            default: row_d = ROW_B;
         endcase
      end else begin
         row_d = row_q;
      end
   end

   always_comb begin
      case (row_q)
         ROW_B:   DRIVE = 4'b0001;
         ROW_G:   DRIVE = 4'b0010;
         ROW_F:   DRIVE = 4'b0100;
         ROW_D:   DRIVE = 4'b1000;
         default: DRIVE = 4'b0001;
      endcase
   end

   keypad_debounce #(
      .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
   ) u_debounce (
      .clk     (CLK),
      .rst     (RST),
      .scan_end(scan_end_s),
      .cand    (cand_s),
      .stable  (stable_s),
      .load    (deb_load_s)
   );

   // Look at the value stable takes this edge so the event lands one cycle after scan end
   assign stable_nx_s = deb_load_s ? cand_s : stable_s;

   always_comb begin
      ev_d        = ev_q;
      new_press_s = 1'b0;
      case (ev_q)
         IDLE: begin
            if (stable_nx_s != KEY_NONE) begin
               ev_d        = HELD;
               new_press_s = 1'b1;
            end else begin
               ev_d = IDLE;
            end
         end
         HELD: begin
            if (stable_nx_s == KEY_NONE) begin
               ev_d = IDLE;
            end else begin
               ev_d = HELD;
            end
         end
         default: ev_d = IDLE;
      endcase
   end

`ifdef KEYPAD_REPEAT_EN
   localparam int RW = $clog2(REPEAT_SCANS + 1);
   localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_SCANS - 1);

   logic [RW-1:0] rep_q;
   logic [RW-1:0] rep_d;
   logic          rep_fire_s;

   // Counts whole scans spent held; cleared on press entry and on release
   always_comb begin
      rep_d      = rep_q;
      rep_fire_s = 1'b0;
      if ((ev_q != HELD) || (ev_d != HELD)) begin
         rep_d = '0;
      end else if (scan_end_s) begin
         if (rep_q == REP_LAST) begin
            rep_d      = '0;
            rep_fire_s = 1'b1;
         end else begin
            rep_d = rep_q + 1'b1;
         end
      end else begin
         rep_d = rep_q;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         rep_q <= '0;
      end else begin
         rep_q <= rep_d;
      end
   end

   assign event_s = new_press_s | rep_fire_s;
`else
   assign event_s = new_press_s;
`endif

   // A new event beats a same-cycle ack; otherwise it is dropped while valid is pending
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      intr_d  = 1'b0;
      if (event_s && (!valid_q || KEY_ACK)) begin
         data_d  = stable_nx_s;
         valid_d = 1'b1;
         intr_d  = 1'b1;
      end else if (KEY_ACK) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   assign KEY_DATA  = data_q;
   assign KEY_VALID = valid_q;
   assign INTR      = intr_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with SCAN_DIV=4, DEBOUNCE_SCANS=2, REPEAT_SCANS=3.
// Cycle t=0 is the first cycle after reset release; a scan is 16 cycles, scan ends at t%16==15.
module tb_keypad_scan_ctrl;

   logic        clk;
   logic        rst;
   logic [2:0]  sense;
   logic [3:0]  drive;
   logic [3:0]  key_data;
   logic        key_valid;
   logic        key_ack;
   logic        intr;
   logic [11:0] keys;

   int t;
   int intr_cnt;
   int last_intr_t;
   int n_checks;
   int n_pass;

   keypad_scan_ctrl #(
      .SCAN_DIV      (4),
      .DEBOUNCE_SCANS(2),
      .REPEAT_SCANS  (3)
   ) dut (
      .CLK      (clk),
      .RST      (rst),
      .SENSE    (sense),
      .DRIVE    (drive),
      .KEY_DATA (key_data),
      .KEY_VALID(key_valid),
      .KEY_ACK  (key_ack),
      .INTR     (intr)
   );

   // Keypad matrix: drive bits {D,F,G,B}, sense bits {E,A,C}
   assign sense[0] = (drive[0] & keys[1]) | (drive[1] & keys[4]) | (drive[2] & keys[7]) | (drive[3] & keys[10]);
   assign sense[1] = (drive[0] & keys[2]) | (drive[1] & keys[5]) | (drive[2] & keys[8]) | (drive[3] & keys[0]);
   assign sense[2] = (drive[0] & keys[3]) | (drive[1] & keys[6]) | (drive[2] & keys[9]) | (drive[3] & keys[11]);

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(negedge clk);
      t = t + 1;
   endtask

   task automatic run_to(input int tgt);
      while (t < tgt) begin
         tick();
         if (intr === 1'b1) begin
            intr_cnt    = intr_cnt + 1;
            last_intr_t = t;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++; if (drive !== 4'b0001) $display("FAIL rst_drive: got %b want %b", drive, 4'b0001); else n_pass++;
      n_checks++; if (key_valid !== 1'b0) $display("FAIL rst_valid: got %b want %b", key_valid, 1'b0); else n_pass++;
      n_checks++; if (key_data !== 4'hF) $display("FAIL rst_data: got %h want %h", key_data, 4'hF); else n_pass++;
      n_checks++; if (intr !== 1'b0) $display("FAIL rst_intr: got %b want %b", intr, 1'b0); else n_pass++;
      rst = 1'b0;
      t = 0;
      intr_cnt = 0;
   endtask

   task automatic test_row_scan();
      run_to(3);
      n_checks++; if (drive !== 4'b0001) $display("FAIL scan_t3: got %b want %b", drive, 4'b0001); else n_pass++;
      run_to(4);
      n_checks++; if (drive !== 4'b0010) $display("FAIL scan_t4: got %b want %b", drive, 4'b0010); else n_pass++;
      run_to(8);
      n_checks++; if (drive !== 4'b0100) $display("FAIL scan_t8: got %b want %b", drive, 4'b0100); else n_pass++;
      run_to(12);
      n_checks++; if (drive !== 4'b1000) $display("FAIL scan_t12: got %b want %b", drive, 4'b1000); else n_pass++;
      run_to(16);
      n_checks++; if (drive !== 4'b0001) $display("FAIL scan_t16: got %b want %b", drive, 4'b0001); else n_pass++;
   endtask

   task automatic test_press_five();
      intr_cnt = 0;
      keys = 12'h020;
      run_to(48);
      n_checks++; if (intr !== 1'b1) $display("FAIL five_intr: got %b want %b", intr, 1'b1); else n_pass++;
      n_checks++; if (key_data !== 4'd5) $display("FAIL five_data: got %h want %h", key_data, 4'd5); else n_pass++;
      n_checks++; if (key_valid !== 1'b1) $display("FAIL five_valid: got %b want %b", key_valid, 1'b1); else n_pass++;
      n_checks++; if (intr_cnt !== 1) $display("FAIL five_intr_cnt: got %0d want %0d", intr_cnt, 1); else n_pass++;
      run_to(50);
      key_ack = 1'b1;
      run_to(51);
      key_ack = 1'b0;
      n_checks++; if (key_valid !== 1'b0) $display("FAIL five_ack: got %b want %b", key_valid, 1'b0); else n_pass++;
      run_to(64);
      keys = 12'h000;
      run_to(96);
      n_checks++; if (intr_cnt !== 1) $display("FAIL five_single_event: got %0d want %0d", intr_cnt, 1); else n_pass++;
      n_checks++; if (key_valid !== 1'b0) $display("FAIL five_valid_end: got %b want %b", key_valid, 1'b0); else n_pass++;
   endtask

   task automatic test_priority_glitch();
      intr_cnt = 0;
      keys = 12'h804;
      run_to(128);
      n_checks++; if (intr !== 1'b1) $display("FAIL prio_intr: got %b want %b", intr, 1'b1); else n_pass++;
      n_checks++; if (key_data !== 4'd2) $display("FAIL prio_data: got %h want %h", key_data, 4'd2); else n_pass++;
      n_checks++; if (intr_cnt !== 1) $display("FAIL prio_intr_cnt: got %0d want %0d", intr_cnt, 1); else n_pass++;
      key_ack = 1'b1;
      run_to(129);
      key_ack = 1'b0;
      keys = 12'h000;
      n_checks++; if (key_valid !== 1'b0) $display("FAIL prio_ack: got %b want %b", key_valid, 1'b0); else n_pass++;
      run_to(160);
      intr_cnt = 0;
      keys = 12'h080;
      run_to(176);
      keys = 12'h000;
      run_to(224);
      n_checks++; if (intr_cnt !== 0) $display("FAIL glitch_intr_cnt: got %0d want %0d", intr_cnt, 0); else n_pass++;
      n_checks++; if (key_valid !== 1'b0) $display("FAIL glitch_valid: got %b want %b", key_valid, 1'b0); else n_pass++;
      n_checks++; if (key_data !== 4'd2) $display("FAIL glitch_data: got %h want %h", key_data, 4'd2); else n_pass++;
   endtask

   task automatic test_back_to_back();
      intr_cnt = 0;
      keys = 12'h002;
      run_to(256);
      n_checks++; if (intr !== 1'b1) $display("FAIL one_intr: got %b want %b", intr, 1'b1); else n_pass++;
      n_checks++; if (key_data !== 4'd1) $display("FAIL one_data: got %h want %h", key_data, 4'd1); else n_pass++;
      n_checks++; if (key_valid !== 1'b1) $display("FAIL one_valid: got %b want %b", key_valid, 1'b1); else n_pass++;
      keys = 12'h000;
      intr_cnt = 0;
      run_to(288);
      keys = 12'h200;
      run_to(330);
      n_checks++; if (intr_cnt !== 0) $display("FAIL drop_intr_cnt: got %0d want %0d", intr_cnt, 0); else n_pass++;
      n_checks++; if (key_data !== 4'd1) $display("FAIL drop_data: got %h want %h", key_data, 4'd1); else n_pass++;
      n_checks++; if (key_valid !== 1'b1) $display("FAIL drop_valid: got %b want %b", key_valid, 1'b1); else n_pass++;
      keys = 12'h000;
      run_to(352);
      keys = 12'h200;
      intr_cnt = 0;
      run_to(383);
      key_ack = 1'b1;
      run_to(384);
      key_ack = 1'b0;
      n_checks++; if (key_valid !== 1'b1) $display("FAIL ackwin_valid: got %b want %b", key_valid, 1'b1); else n_pass++;
      n_checks++; if (key_data !== 4'd9) $display("FAIL ackwin_data: got %h want %h", key_data, 4'd9); else n_pass++;
      n_checks++; if (intr !== 1'b1) $display("FAIL ackwin_intr: got %b want %b", intr, 1'b1); else n_pass++;
      n_checks++; if (intr_cnt !== 1) $display("FAIL ackwin_intr_cnt: got %0d want %0d", intr_cnt, 1); else n_pass++;
   endtask

   task automatic test_mid_reset();
      run_to(393);
      rst = 1'b1;
      run_to(394);
      n_checks++; if (drive !== 4'b0001) $display("FAIL mrst_drive: got %b want %b", drive, 4'b0001); else n_pass++;
      n_checks++; if (key_valid !== 1'b0) $display("FAIL mrst_valid: got %b want %b", key_valid, 1'b0); else n_pass++;
      n_checks++; if (key_data !== 4'hF) $display("FAIL mrst_data: got %h want %h", key_data, 4'hF); else n_pass++;
      n_checks++; if (intr !== 1'b0) $display("FAIL mrst_intr: got %b want %b", intr, 1'b0); else n_pass++;
      rst = 1'b0;
      keys = 12'h000;
      t = 0;
      intr_cnt = 0;
      run_to(3);
      n_checks++; if (drive !== 4'b0001) $display("FAIL mrst_t3: got %b want %b", drive, 4'b0001); else n_pass++;
      run_to(4);
      n_checks++; if (drive !== 4'b0010) $display("FAIL mrst_t4: got %b want %b", drive, 4'b0010); else n_pass++;
      run_to(16);
      n_checks++; if (drive !== 4'b0001) $display("FAIL mrst_t16: got %b want %b", drive, 4'b0001); else n_pass++;
      n_checks++; if (intr_cnt !== 0) $display("FAIL mrst_intr_cnt: got %0d want %0d", intr_cnt, 0); else n_pass++;
   endtask

`ifdef KEYPAD_REPEAT_EN
   task automatic test_repeat();
      int n_ev;
      n_ev = 0;
      keys = 12'h001;
      while (t < 272) begin
         tick();
         if (intr === 1'b1) begin
            if (n_ev < 4) begin
               n_checks++; if (t !== 48 * (n_ev + 1)) $display("FAIL rep_time%0d: got %0d want %0d", n_ev, t, 48 * (n_ev + 1)); else n_pass++;
               n_checks++; if (key_data !== 4'd0) $display("FAIL rep_data%0d: got %h want %h", n_ev, key_data, 4'd0); else n_pass++;
            end
            n_ev = n_ev + 1;
         end
         key_ack = (key_valid === 1'b1);
         if (t == 200) keys = 12'h000;
      end
      key_ack = 1'b0;
      n_checks++; if (n_ev !== 4) $display("FAIL rep_count: got %0d want %0d", n_ev, 4); else n_pass++;
   endtask
`endif

   initial begin
      rst = 1'b1;
      keys = 12'h000;
      key_ack = 1'b0;
      t = 0;
      intr_cnt = 0;
      last_intr_t = 0;
      n_checks = 0;
      n_pass = 0;
      test_reset();
      test_row_scan();
      test_press_five();
      test_priority_glitch();
      test_back_to_back();
      test_mid_reset();
`ifdef KEYPAD_REPEAT_EN
      test_repeat();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
